// File: rtl/edge_pkg.sv
// ---------------------------------------------------------------------------
// edge_pkg
// Shared constants and types for the edge-centroid reduction block.
//   WIDTH, HEIGHT  default frame geometry (pixels)
//   PIXELS         default frame size, WIDTH*HEIGHT
//   ADDR_W         edge BRAM address width
//   SUM_W          coordinate-sum accumulator width (639*307200 fits)
//   COUNT_W        edge-pixel counter width
//   X_W, Y_W       column / row coordinate widths
//   state_t        scan controller states
//   tag_t          coordinate tag travelling alongside a BRAM read
// ---------------------------------------------------------------------------
package edge_pkg;

    localparam int WIDTH   = 640;
    localparam int HEIGHT  = 480;
    localparam int PIXELS  = WIDTH * HEIGHT;
    localparam int ADDR_W  = 19;
    localparam int SUM_W   = 28;
    localparam int COUNT_W = 19;
    localparam int X_W     = 10;
    localparam int Y_W     = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_DIV_X,
        ST_DIV_Y,
        ST_DONE
    } state_t;

    // Pixel coordinate of an outstanding read; valid marks a real scan sample.
    typedef struct packed {
        logic           valid;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } tag_t;

endpackage

// File: rtl/edge_divider.sv
// ---------------------------------------------------------------------------
// edge_divider
// Restoring unsigned divider, SUM_W-bit dividend by COUNT_W-bit divisor,
// one quotient bit per cycle, truncating quotient.
//   clk, rst_n  clock, asynchronous active-low reset
//   start       one-cycle pulse: load operands and begin
//   abort       drop any division in progress (no done pulse)
//   dividend    numerator, sampled on start
//   divisor     denominator, sampled on start; must be non-zero
//   quotient    floor(dividend / divisor), valid while done is high
//   done        one-cycle pulse, SUM_W+1 cycles after start
// ---------------------------------------------------------------------------
module edge_divider
    import edge_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [SUM_W-1:0]   dividend,
    input  logic [COUNT_W-1:0] divisor,
    output logic [SUM_W-1:0]   quotient,
    output logic               done
);

    localparam int STEP_W = $clog2(SUM_W + 1);

    // The partial remainder is always below the divisor, so one extra bit
    // holds the shifted value and a second extra bit carries the borrow.
    logic [COUNT_W:0]   rem;
    logic [COUNT_W-1:0] dvsr;
    logic [STEP_W-1:0]  steps;
    logic               busy;
    logic [COUNT_W:0]   shifted;
    logic [COUNT_W+1:0] diff;

    always_comb begin
        shifted = {rem[COUNT_W-1:0], quotient[SUM_W-1]};
        diff    = {1'b0, shifted} - {2'b00, dvsr};
    end

    // The dividend register doubles as the quotient shift register: each
    // step consumes its MSB and shifts a quotient bit in at the LSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      <= '0;
            dvsr     <= '0;
            steps    <= '0;
            busy     <= 1'b0;
            quotient <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                busy <= 1'b0;
            end else if (start) begin
                rem      <= '0;
                dvsr     <= divisor;
                quotient <= dividend;
                steps    <= STEP_W'(SUM_W);
                busy     <= 1'b1;
            end else if (busy) begin
                if (!diff[COUNT_W+1]) begin
                    rem      <= diff[COUNT_W:0];
                    quotient <= {quotient[SUM_W-2:0], 1'b1};
                end else begin
                    rem      <= shifted;
                    quotient <= {quotient[SUM_W-2:0], 1'b0};
                end
                steps <= steps - 1'b1;
                if (steps == STEP_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/edge_centroid.sv
// ---------------------------------------------------------------------------
// edge_centroid
// Scans every edge flag of a filled edge BRAM once and reduces the frame to
// an edge-pixel count, a bounding box and an integer centroid.
//   clk, rst_n        clock, asynchronous active-low reset
//   start             level: high requests a scan, low aborts / acknowledges
//   done              high in the result state while start is still high
//   edge_data         BRAM read data, bit 0 is the edge flag
//   edge_memory_addr  registered BRAM read address
//   edge_count        edge pixels found by the last completed scan
//   x_min/x_max       bounding-box columns
//   y_min/y_max       bounding-box rows
//   x_centroid        floor(sum_x / edge_count)
//   y_centroid        floor(sum_y / edge_count)
//   valid             last completed scan found at least one edge pixel
// Result outputs only change on entry to ST_DONE, so an aborted or partial
// scan is never visible downstream.
// ---------------------------------------------------------------------------
module edge_centroid #(
    parameter int WIDTH        = edge_pkg::WIDTH,
    parameter int HEIGHT       = edge_pkg::HEIGHT,
    parameter int READ_LATENCY = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic                         done,
    input  logic [3:0]                   edge_data,
    output logic [edge_pkg::ADDR_W-1:0]  edge_memory_addr,
    output logic [edge_pkg::COUNT_W-1:0] edge_count,
    output logic [edge_pkg::X_W-1:0]     x_min,
    output logic [edge_pkg::X_W-1:0]     x_max,
    output logic [edge_pkg::Y_W-1:0]     y_min,
    output logic [edge_pkg::Y_W-1:0]     y_max,
    output logic [edge_pkg::X_W-1:0]     x_centroid,
    output logic [edge_pkg::Y_W-1:0]     y_centroid,
    output logic                         valid
);

    localparam int ADDR_W  = edge_pkg::ADDR_W;
    localparam int SUM_W   = edge_pkg::SUM_W;
    localparam int COUNT_W = edge_pkg::COUNT_W;
    localparam int X_W     = edge_pkg::X_W;
    localparam int Y_W     = edge_pkg::Y_W;
    localparam int PIXELS  = WIDTH * HEIGHT;
    localparam int DRAIN_W = $clog2(READ_LATENCY + 1);

    edge_pkg::state_t state, state_next;

    logic [ADDR_W-1:0]  addr_q;
    logic [X_W-1:0]     x_cnt;
    logic [Y_W-1:0]     y_cnt;
    logic [DRAIN_W-1:0] drain_cnt;
    edge_pkg::tag_t     tag_in;
    edge_pkg::tag_t     pipe [READ_LATENCY];
    logic               sample_hit;

    logic [COUNT_W-1:0] acc_count;
    logic [SUM_W-1:0]   acc_sum_x;
    logic [SUM_W-1:0]   acc_sum_y;
    logic [X_W-1:0]     acc_x_min, acc_x_max;
    logic [Y_W-1:0]     acc_y_min, acc_y_max;

    logic               launched;
    logic [X_W-1:0]     qx;
    logic               commit;
    logic               div_start;
    logic [SUM_W-1:0]   div_dividend;
    logic [SUM_W-1:0]   div_quotient;
    logic               div_done;
    logic               unused_bits;

    logic scan_last, drain_last;
    assign scan_last  = (addr_q == ADDR_W'(PIXELS - 1));
    assign drain_last = (drain_cnt == DRAIN_W'(READ_LATENCY - 1));

    // ---------------------------------------------------------------- FSM
    // NOTE: sequential state is written with non-blocking assignments so
    // every register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= edge_pkg::ST_IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of this block gets a default before the case, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next   = state;
        div_start    = 1'b0;
        div_dividend = acc_sum_y;
        commit       = 1'b0;
        case (state)
            edge_pkg::ST_IDLE: begin
                if (start) state_next = edge_pkg::ST_SCAN;
            end
            edge_pkg::ST_SCAN: begin
                if (!start)         state_next = edge_pkg::ST_IDLE;
                else if (scan_last) state_next = edge_pkg::ST_DRAIN;
            end
            edge_pkg::ST_DRAIN: begin
                if (!start)          state_next = edge_pkg::ST_IDLE;
                else if (drain_last) state_next = edge_pkg::ST_DIV_X;
            end
            edge_pkg::ST_DIV_X: begin
                // Accumulators are final here; an empty frame skips both
                // divisions. The y division is launched in the same cycle
                // the x quotient comes back.
                if (!start) begin
                    state_next = edge_pkg::ST_IDLE;
                end else if (acc_count == '0) begin
                    state_next = edge_pkg::ST_DONE;
                    commit     = 1'b1;
                end else if (!launched) begin
                    div_start    = 1'b1;
                    div_dividend = acc_sum_x;
                end else if (div_done) begin
                    div_start  = 1'b1;
                    state_next = edge_pkg::ST_DIV_Y;
                end
            end
            edge_pkg::ST_DIV_Y: begin
                if (!start) begin
                    state_next = edge_pkg::ST_IDLE;
                end else if (div_done) begin
                    state_next = edge_pkg::ST_DONE;
                    commit     = 1'b1;
                end
            end
            edge_pkg::ST_DONE: begin
                if (!start) state_next = edge_pkg::ST_IDLE;
            end
            default: state_next = edge_pkg::ST_IDLE;
        endcase
    end

    assign done = (state == edge_pkg::ST_DONE);

    // ------------------------------------------------- address generator
    // Address and coordinates advance only while the scan continues; any
    // other case (idle, abort, end of frame) parks them at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            x_cnt  <= '0;
            y_cnt  <= '0;
        end else if (state == edge_pkg::ST_SCAN && state_next == edge_pkg::ST_SCAN) begin
            addr_q <= addr_q + 1'b1;
            if (x_cnt == X_W'(WIDTH - 1)) begin
                x_cnt <= '0;
                y_cnt <= y_cnt + 1'b1;
            end else begin
                x_cnt <= x_cnt + 1'b1;
            end
        end else begin
            addr_q <= '0;
            x_cnt  <= '0;
            y_cnt  <= '0;
        end
    end

    assign edge_memory_addr = addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          drain_cnt <= '0;
        else if (state == edge_pkg::ST_DRAIN) drain_cnt <= drain_cnt + 1'b1;
        else                                 drain_cnt <= '0;
    end

    // ------------------------------------------------- alignment delay line
    // A sample issued in the cycle that sees start low belongs to an aborted
    // scan, so it is never marked valid.
    always_comb begin
        tag_in.valid = (state == edge_pkg::ST_SCAN) && start;
        tag_in.x     = x_cnt;
        tag_in.y     = y_cnt;
    end

    // NOTE: the delay line is a handful of flops, not a RAM, so it is reset
    // along with everything else; only the external BRAM is left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < READ_LATENCY; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= tag_in;
            for (int i = 1; i < READ_LATENCY; i++) pipe[i] <= pipe[i-1];
            // Flush stale tags so a quick restart cannot pick up leftovers.
            if (state == edge_pkg::ST_IDLE) begin
                for (int i = 0; i < READ_LATENCY; i++) pipe[i].valid <= 1'b0;
            end
        end
    end

    assign sample_hit = pipe[READ_LATENCY-1].valid && edge_data[0] &&
                        (state == edge_pkg::ST_SCAN || state == edge_pkg::ST_DRAIN);

    // ------------------------------------------------- accumulators
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_count <= '0;
            acc_sum_x <= '0;
            acc_sum_y <= '0;
            acc_x_min <= '0;
            acc_x_max <= '0;
            acc_y_min <= '0;
            acc_y_max <= '0;
        end else if (state == edge_pkg::ST_IDLE) begin
            acc_count <= '0;
            acc_sum_x <= '0;
            acc_sum_y <= '0;
            acc_x_min <= '0;
            acc_x_max <= '0;
            acc_y_min <= '0;
            acc_y_max <= '0;
        end else if (sample_hit) begin
            acc_count <= acc_count + 1'b1;
            acc_sum_x <= acc_sum_x + SUM_W'(pipe[READ_LATENCY-1].x);
            acc_sum_y <= acc_sum_y + SUM_W'(pipe[READ_LATENCY-1].y);
            // The first edge pixel seeds both ends of the bounding box.
            if (acc_count == '0) begin
                acc_x_min <= pipe[READ_LATENCY-1].x;
                acc_x_max <= pipe[READ_LATENCY-1].x;
                acc_y_min <= pipe[READ_LATENCY-1].y;
                acc_y_max <= pipe[READ_LATENCY-1].y;
            end else begin
                if (pipe[READ_LATENCY-1].x < acc_x_min) acc_x_min <= pipe[READ_LATENCY-1].x;
                if (pipe[READ_LATENCY-1].x > acc_x_max) acc_x_max <= pipe[READ_LATENCY-1].x;
                if (pipe[READ_LATENCY-1].y < acc_y_min) acc_y_min <= pipe[READ_LATENCY-1].y;
                if (pipe[READ_LATENCY-1].y > acc_y_max) acc_y_max <= pipe[READ_LATENCY-1].y;
            end
        end
    end

    // ------------------------------------------------- divider
    edge_divider u_divider (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .abort    (state == edge_pkg::ST_IDLE),
        .dividend (div_dividend),
        .divisor  (acc_count),
        .quotient (div_quotient),
        .done     (div_done)
    );

    // launched marks that the x division has been kicked off in this visit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            launched <= 1'b0;
            qx       <= '0;
        end else begin
            launched <= (state == edge_pkg::ST_DIV_X);
            if (state == edge_pkg::ST_DIV_X && div_done) qx <= div_quotient[X_W-1:0];
        end
    end

    // A centroid never exceeds the frame, so only the low quotient bits matter.
    assign unused_bits = ^{edge_data[3:1], div_quotient[SUM_W-1:X_W]};

    // ------------------------------------------------- result commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_count <= '0;
            x_min      <= '0;
            x_max      <= '0;
            y_min      <= '0;
            y_max      <= '0;
            x_centroid <= '0;
            y_centroid <= '0;
            valid      <= 1'b0;
        end else if (commit) begin
            edge_count <= acc_count;
            valid      <= (acc_count != '0);
            if (acc_count == '0) begin
                x_min      <= '0;
                x_max      <= '0;
                y_min      <= '0;
                y_max      <= '0;
                x_centroid <= '0;
                y_centroid <= '0;
            end else begin
                x_min      <= acc_x_min;
                x_max      <= acc_x_max;
                y_min      <= acc_y_min;
                y_max      <= acc_y_max;
                x_centroid <= qx;
                y_centroid <= div_quotient[Y_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_edge_centroid.sv
// ---------------------------------------------------------------------------
// tb_edge_centroid
// Directed bench for edge_centroid on a reduced 104x56 frame. A reference
// model walks the BRAM image with plain arithmetic to produce the expected
// results; a compare process checks the result outputs every cycle (old
// results while a scan runs, new results once done is high). Directed
// literal checks pin the model on hand-computed frames.
// ---------------------------------------------------------------------------
module tb_edge_centroid;

    localparam int W       = 104;
    localparam int H       = 56;
    localparam int RL      = 2;
    localparam int P       = W * H;
    localparam int DIV_CYC = 58;

    typedef struct packed {
        logic [18:0] cnt;
        logic [9:0]  xmn;
        logic [9:0]  xmx;
        logic [8:0]  ymn;
        logic [8:0]  ymx;
        logic [9:0]  xc;
        logic [8:0]  yc;
        logic        vld;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        done;
    logic [3:0]  edge_data;
    logic [18:0] edge_memory_addr;
    logic [18:0] edge_count;
    logic [9:0]  x_min, x_max, x_centroid;
    logic [8:0]  y_min, y_max, y_centroid;
    logic        valid;

    logic [3:0]  mem [0:P-1];
    logic [3:0]  rd1 = 4'h0;
    logic [3:0]  rd2 = 4'h0;

    int   n_cmp = 0;
    int   n_bad = 0;
    bit   chk_on = 1'b0;
    res_t held = '0;
    res_t pending = '0;
    res_t got;

    edge_centroid #(.WIDTH(W), .HEIGHT(H), .READ_LATENCY(RL)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .done             (done),
        .edge_data        (edge_data),
        .edge_memory_addr (edge_memory_addr),
        .edge_count       (edge_count),
        .x_min            (x_min),
        .x_max            (x_max),
        .y_min            (y_min),
        .y_max            (y_max),
        .x_centroid       (x_centroid),
        .y_centroid       (y_centroid),
        .valid            (valid)
    );

    always #5 clk = ~clk;

    // Two-cycle BRAM read port.
    always @(posedge clk) begin
        rd1 <= (int'(edge_memory_addr) < P) ? mem[edge_memory_addr] : 4'h0;
        rd2 <= rd1;
    end
    assign edge_data = rd2;

    assign got = {edge_count, x_min, x_max, y_min, y_max, x_centroid, y_centroid, valid};

    // Result outputs every cycle: old results until done, new ones with done.
    always @(negedge clk) begin
        if (chk_on && rst_n) begin
            n_cmp++;
            if (got !== (done ? pending : held)) begin
                n_bad++;
                $display("FAIL results @%0t: got %h want %h (done=%0b)", $time, got,
                         done ? pending : held, done);
            end
        end
    end

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference model: straight walk of the frame image.
    task automatic model(output res_t r);
        longint sx, sy;
        int cnt, xmn, xmx, ymn, ymx;
        cnt = 0; sx = 0; sy = 0;
        xmn = W; xmx = -1; ymn = H; ymx = -1;
        for (int a = 0; a < P; a++) begin
            if (mem[a][0]) begin
                int x = a % W;
                int y = a / W;
                cnt++;
                sx += x;
                sy += y;
                if (x < xmn) xmn = x;
                if (x > xmx) xmx = x;
                if (y < ymn) ymn = y;
                if (y > ymx) ymx = y;
            end
        end
        r = '0;
        if (cnt != 0) begin
            r.cnt = 19'(cnt);
            r.xmn = 10'(xmn);
            r.xmx = 10'(xmx);
            r.ymn = 9'(ymn);
            r.ymx = 9'(ymx);
            r.xc  = 10'(sx / cnt);
            r.yc  = 9'(sy / cnt);
            r.vld = 1'b1;
        end
    endtask

    task automatic fill(input logic [3:0] v);
        for (int a = 0; a < P; a++) mem[a] = v;
    endtask

    task automatic fill_random(input int one_in);
        for (int a = 0; a < P; a++) begin
            mem[a] = {3'($urandom_range(0, 7)), ($urandom_range(0, one_in - 1) == 0)};
        end
    endtask

    task automatic run_scan(input string name);
        res_t m;
        int   n, exp_lat;
        bit   seen;
        model(m);
        pending = m;
        exp_lat = m.vld ? P + RL + DIV_CYC + 1 : P + RL + 1;
        @(negedge clk);
        start = 1'b1;
        n = 0;
        seen = 1'b0;
        while (!seen && n < P + 400) begin
            @(negedge clk);
            n++;
            if (done) seen = 1'b1;
        end
        n_cmp++;
        if (!seen || n < exp_lat - 2 || n > exp_lat + 2) begin
            n_bad++;
            $display("FAIL %s latency: got %0d cycles (seen=%0b) want %0d +/-2", name, n, seen, exp_lat);
        end
        held = pending;
        repeat (2) @(negedge clk);
        check({name, " done_hold"}, 96'(done), 96'(1));
        start = 1'b0;
        @(negedge clk);
        check({name, " done_drop"}, 96'(done), 96'(0));
        @(negedge clk);
    endtask

    // Wait (bounded) until the scan reaches a given address.
    task automatic wait_addr(input string name, input int target);
        int n;
        n = 0;
        while (int'(edge_memory_addr) != target && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check({name, " reach_addr"}, 96'(edge_memory_addr), 96'(target));
    endtask

    task automatic watch_no_done(input string name, input int cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check({name, " no_done"}, 96'(seen), 96'(0));
    endtask

    initial begin
        fill(4'h0);
        #1 rst_n = 1'b0;
        #2;
        check("rst done", 96'(done), 96'(0));
        check("rst addr", 96'(edge_memory_addr), 96'(0));
        check("rst results", 96'(got), 96'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk_on = 1'b1;
        @(negedge clk);

        // Empty frame.
        run_scan("zero");
        check("zero count", 96'(edge_count), 96'(0));
        check("zero valid", 96'(valid), 96'(0));
        check("zero bbox", 96'({x_min, x_max, y_min, y_max}), 96'(0));
        check("zero centroid", 96'({x_centroid, y_centroid}), 96'(0));

        // Single flag at (100,50).
        fill(4'h0);
        mem[50 * W + 100] = 4'b0001;
        run_scan("single");
        check("single count", 96'(edge_count), 96'(1));
        check("single x_min", 96'(x_min), 96'(100));
        check("single x_max", 96'(x_max), 96'(100));
        check("single y_min", 96'(y_min), 96'(50));
        check("single y_max", 96'(y_max), 96'(50));
        check("single x_centroid", 96'(x_centroid), 96'(100));
        check("single y_centroid", 96'(y_centroid), 96'(50));
        check("single valid", 96'(valid), 96'(1));

        // Two flags: (10,10) and (21,30).
        fill(4'h0);
        mem[10 * W + 10] = 4'b0001;
        mem[30 * W + 21] = 4'b0001;
        run_scan("two");
        check("two count", 96'(edge_count), 96'(2));
        check("two bbox_x", 96'({x_min, x_max}), 96'({10'd10, 10'd21}));
        check("two bbox_y", 96'({y_min, y_max}), 96'({9'd10, 9'd30}));
        check("two centroid", 96'({x_centroid, y_centroid}), 96'({10'd15, 9'd20}));

        // Every pixel an edge: 5824 pixels, centroid floor(51.5), floor(27.5).
        fill(4'b0001);
        run_scan("all_ones");
        check("all count", 96'(edge_count), 96'(5824));
        check("all bbox_x", 96'({x_min, x_max}), 96'({10'd0, 10'd103}));
        check("all bbox_y", 96'({y_min, y_max}), 96'({9'd0, 9'd55}));
        check("all centroid", 96'({x_centroid, y_centroid}), 96'({10'd51, 9'd27}));

        // Upper bits set, flag clear: no edges.
        fill(4'b1110);
        run_scan("ignored_bits");
        check("ign count", 96'(edge_count), 96'(0));
        check("ign valid", 96'(valid), 96'(0));
        check("ign bbox", 96'({x_min, x_max, y_min, y_max}), 96'(0));

        // Sparse random frame with noise in the ignored bits.
        fill_random(8);
        run_scan("random");

        // Abort at address 1000: no done, results unchanged, address parked.
        fill(4'b0001);
        @(negedge clk);
        start = 1'b1;
        wait_addr("abort", 1000);
        start = 1'b0;
        watch_no_done("abort", 100);
        check("abort addr", 96'(edge_memory_addr), 96'(0));
        check("abort count_kept", 96'(edge_count), 96'(held.cnt));

        // One-cycle start pulse.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        watch_no_done("pulse", 100);

        // Reset in the middle of a scan clears every output.
        fill_random(5);
        @(negedge clk);
        start = 1'b1;
        wait_addr("reset", 2000);
        #2;
        held = '0;
        pending = '0;
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        check("midrst results", 96'(got), 96'(0));
        check("midrst addr", 96'(edge_memory_addr), 96'(0));
        check("midrst done", 96'(done), 96'(0));
        @(negedge clk);
        rst_n = 1'b1;
        watch_no_done("midrst", 20);

        // A full scan after the reset produces the right answer.
        run_scan("after_reset");
        check("after_reset valid", 96'(valid), 96'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
